hv_bundler_stream: RTL and testbench

Streaming majority bundler for hypervectors, the handshaked successor to the continuous bundler in the HDC methods library. It accumulates per-dimension bit counts over a variable number of input hypervectors and, on a finish request, emits a majority-thresholded result.
- Input uses a valid/ready handshake with back-pressure on counter saturation.
- Output is held under valid/ready.
- Accumulation of the next bundle may overlap the output hold.
- It sits between the encoder (spatial/temporal binding) and the associative-memory classifier.

---
 rtl/hv_bundler_stream.sv | 135 +++++++++++++
 tb/tb_hv_bundler_stream.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hv_bundler_stream.sv
// Streaming majority bundler: accumulates per-dimension bit counts under valid/ready
// and emits a thresholded hypervector on finish. Optional tie-break: HV_BUNDLER_TIEBREAK_EN.
//
// state  | meaning
// ACCUM  | accepting beats, waiting for finish
// DECIDE | one cycle: threshold counters into hv_out, clear accumulators
// OUTPUT | result held under out_valid; new beats accumulate meanwhile
module hv_bundler_stream #(
    parameter int DIMENSIONS = 10000,
    parameter int COUNT_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIMENSIONS-1:0] hv_in,
    input  logic                  finish,
    input  logic [DIMENSIONS-1:0] tie_hv,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIMENSIONS-1:0] hv_out,
    output logic [COUNT_SIZE-1:0] hv_count,
    output logic                  full
);

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DECIDE = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    localparam logic [COUNT_SIZE-1:0] MAX_COUNT = '1;

    state_t                  state_q, state_d;
    logic [COUNT_SIZE-1:0]   count_q, count_d;
    logic [DIMENSIONS-1:0]   hv_out_q, hv_out_d;
    logic [COUNT_SIZE-1:0]   hv_count_q, hv_count_d;
    logic                    out_valid_q, out_valid_d;
    logic [DIMENSIONS-1:0]   dec_vec;
    logic                    accept;
    logic                    clear;
    logic                    count_nz;

    assign in_ready  = ((state_q == ACCUM) || (state_q == OUTPUT)) && (count_q != MAX_COUNT);
    assign full      = (count_q == MAX_COUNT);
    assign accept    = in_valid && in_ready;
    assign clear     = (state_q == DECIDE);
    assign count_nz  = (count_q != '0);
    assign out_valid = out_valid_q;
    assign hv_out    = hv_out_q;
    assign hv_count  = hv_count_q;

    // Back-pressure at MAX_COUNT bounds every counter, so no saturation is needed.
    for (genvar i = 0; i < DIMENSIONS; i++) begin : g_dim
        logic [COUNT_SIZE-1:0] ctr_q;
        logic                  gt;
        logic                  eq;

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                ctr_q <= '0;
            end else if (clear) begin
                ctr_q <= '0;
            end else if (accept && hv_in[i]) begin
                ctr_q <= ctr_q + 1'b1;
            end
        end

        assign gt = {ctr_q, 1'b0} >  {1'b0, count_q};
        assign eq = {ctr_q, 1'b0} == {1'b0, count_q};
`ifdef HV_BUNDLER_TIEBREAK_EN
        assign dec_vec[i] = count_nz && (gt || (eq && tie_hv[i]));
`else
        assign dec_vec[i] = count_nz && gt;
        logic unused_eq;
        assign unused_eq = eq;
`endif
    end

`ifndef HV_BUNDLER_TIEBREAK_EN
    logic unused_tie;
    assign unused_tie = ^tie_hv;
`endif

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        hv_out_d    = hv_out_q;
        hv_count_d  = hv_count_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            count_d = count_q + 1'b1;
        end
        case (state_q)
            ACCUM: begin
                if (finish) begin
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                hv_out_d    = dec_vec;
                hv_count_d  = count_q;
                count_d     = '0;
                out_valid_d = 1'b1;
                state_d     = OUTPUT;
            end
            OUTPUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ACCUM;
            count_q     <= '0;
            hv_out_q    <= '0;
            hv_count_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            hv_out_q    <= hv_out_d;
            hv_count_q  <= hv_count_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_hv_bundler_stream.sv
// Bench for hv_bundler_stream (DIMENSIONS=8, COUNT_SIZE=4): per-cycle model compare
// plus directed scenarios with literal expectations.
module tb_hv_bundler_stream;

    localparam int D  = 8;
    localparam int CS = 4;
    localparam int MAXC = 15;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [D-1:0]  hv_in = '0;
    logic          finish = 1'b0;
    logic [D-1:0]  tie_hv = 8'hA5;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [D-1:0]  hv_out;
    logic [CS-1:0] hv_count;
    logic          full;

    int n_cmp  = 0;
    int n_fail = 0;

    hv_bundler_stream #(.DIMENSIONS(D), .COUNT_SIZE(CS)) dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
        .hv_in(hv_in), .finish(finish), .tie_hv(tie_hv), .out_valid(out_valid),
        .out_ready(out_ready), .hv_out(hv_out), .hv_count(hv_count), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: bundle contents as per-bit ones tallies plus a beat count; phase 0/1/2 =
    // collecting, deciding, presenting.
    int           m_ones [D];
    int           m_beats;
    int           m_phase;
    logic [D-1:0] m_out;
    int           m_cnt;
    bit           m_valid;

    function automatic bit m_ready();
        return (m_phase != 1) && (m_beats != MAXC);
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            foreach (m_ones[i]) m_ones[i] = 0;
            m_beats = 0; m_phase = 0; m_out = '0; m_cnt = 0; m_valid = 0;
        end else begin
            automatic bit acc = in_valid && m_ready();
            if (acc && m_phase != 1) begin
                for (int i = 0; i < D; i++) m_ones[i] += int'(hv_in[i]);
                m_beats++;
            end
            case (m_phase)
                0: if (finish) m_phase = 1;
                1: begin
                    for (int i = 0; i < D; i++) begin
                        if (m_beats == 0)                  m_out[i] = 1'b0;
                        else if (2 * m_ones[i] > m_beats)  m_out[i] = 1'b1;
                        else if (2 * m_ones[i] == m_beats)
`ifdef HV_BUNDLER_TIEBREAK_EN
                                                           m_out[i] = tie_hv[i];
`else
                                                           m_out[i] = 1'b0;
`endif
                        else                               m_out[i] = 1'b0;
                    end
                    m_cnt = m_beats;
                    foreach (m_ones[i]) m_ones[i] = 0;
                    m_beats = 0; m_valid = 1; m_phase = 2;
                end
                default: if (out_ready) begin m_valid = 0; m_phase = 0; end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("in_ready",  32'(in_ready),  32'(m_ready()));
        chk("full",      32'(full),      32'(m_beats == MAXC));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("hv_out",    32'(hv_out),    32'(m_out));
        chk("hv_count",  32'(hv_count),  32'(m_cnt));
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic beat(input logic [D-1:0] v, input logic fin);
        in_valid = 1'b1; hv_in = v; finish = fin;
        tick();
        in_valid = 1'b0; finish = 1'b0;
    endtask

    task automatic fin_only();
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!out_valid && k < 20) begin tick(); k++; end
        chk(name, 32'(out_valid), 32'd1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    int acc_n;
    logic [D-1:0] tie_exp;

    initial begin
`ifdef HV_BUNDLER_TIEBREAK_EN
        tie_exp = 8'hA5;
`else
        tie_exp = 8'h00;
`endif
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_hv_out",    32'(hv_out),    32'd0);
        chk("rst_hv_count",  32'(hv_count),  32'd0);
        chk("rst_full",      32'(full),      32'd0);
        nrst = 1'b1;
        tick();

        // Odd-count majority and finish latency
        beat(8'hF0, 1'b0); beat(8'hCC, 1'b0); beat(8'hAA, 1'b0);
        fin_only();
        chk("t1_decide_valid_low", 32'(out_valid), 32'd0);
        chk("t1_decide_ready_low", 32'(in_ready),  32'd0);
        tick();
        chk("t1_valid",    32'(out_valid), 32'd1);
        chk("t1_hv_out",   32'(hv_out),    32'hE8);
        chk("t1_hv_count", 32'(hv_count),  32'd3);
        consume();

        // Tie handling
        beat(8'hFF, 1'b0); beat(8'h00, 1'b0);
        fin_only(); tick();
        chk("t2_hv_out",   32'(hv_out),   32'(tie_exp));
        chk("t2_hv_count", 32'(hv_count), 32'd2);
        consume();

        // Saturation
        acc_n = 0;
        in_valid = 1'b1; hv_in = 8'h01;
        for (int c = 0; c < 20; c++) begin
            if (in_ready) acc_n++;
            tick();
        end
        in_valid = 1'b0;
        chk("t3_accepted", 32'(acc_n),    32'd15);
        chk("t3_full",     32'(full),     32'd1);
        chk("t3_in_ready", 32'(in_ready), 32'd0);
        fin_only();
        wait_valid("t3_wait_valid");
        chk("t3_hv_out",   32'(hv_out),   32'h01);
        chk("t3_hv_count", 32'(hv_count), 32'd15);

        // Overlap with back-pressure on the output
        for (int c = 0; c < 10; c++) begin
            if (c == 1 || c == 4 || c == 7) beat(8'h0F, 1'b0);
            else tick();
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
        end
        chk("t4_hold_hv_out",   32'(hv_out),   32'h01);
        chk("t4_hold_hv_count", 32'(hv_count), 32'd15);
        consume();
        fin_only();
        wait_valid("t4_wait_valid");
        chk("t4_hv_out",   32'(hv_out),   32'h0F);
        chk("t4_hv_count", 32'(hv_count), 32'd3);
        consume();

        // Accept together with finish, then empty finish
        beat(8'h3C, 1'b1);
        wait_valid("t5_wait_valid");
        chk("t5_hv_out",   32'(hv_out),   32'h3C);
        chk("t5_hv_count", 32'(hv_count), 32'd1);
        consume();
        fin_only();
        wait_valid("t5e_wait_valid");
        chk("t5e_hv_out",   32'(hv_out),   32'h00);
        chk("t5e_hv_count", 32'(hv_count), 32'd0);
        consume();

        // Reset during OUTPUT
        beat(8'h55, 1'b0); beat(8'h55, 1'b0);
        fin_only();
        wait_valid("t6_wait_valid");
        beat(8'hFF, 1'b0);
        #2 nrst = 1'b0;
        #1;
        chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_hv_out",    32'(hv_out),    32'd0);
        chk("t6_rst_hv_count",  32'(hv_count),  32'd0);
        tick(); tick();
        nrst = 1'b1;
        beat(8'h81, 1'b0); beat(8'h81, 1'b0);
        fin_only();
        wait_valid("t6_wait_valid2");
        chk("t6_hv_out",   32'(hv_out),   32'h81);
        chk("t6_hv_count", 32'(hv_count), 32'd2);
        consume();
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
